// File: rtl/mac_lane_array_if.sv
// ---------------------------------------------------------------------------
// mac_lane_array_if
// Bundles the operand-side and result-side handshake buses of mac_lane_array.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. The producer holds its payload stable
// while valid && !ready; ready never depends on the same-cycle payload.
//
// Signals
//   a_in, b_in   packed signed operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   psum_in      packed external partial sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   acc_src      base select: 0 internal acc, 1 zero, 2 psum_in, 3 as zero
//   last         beat closes the accumulation and produces a result
//   reduce_mode  0 per-lane results, 1 cross-lane sum in slot 0
//   out_scale    arithmetic right shift applied before saturation
//   in_valid / in_ready    operand beat handshake
//   out_data, out_sat      packed results and per-slot clip flags
//   out_valid / out_ready  result handshake
//   busy         high while flushing or while a result is pending
// Modports
//   master  the controller/testbench side
//   slave   the datapath side
// ---------------------------------------------------------------------------
interface mac_lane_array_if #(
    parameter int NB_LANES   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int MAX_SCALE  = 31
);
    localparam int SCALE_W = $clog2(MAX_SCALE + 1);

    logic [NB_LANES*DATA_WIDTH-1:0] a_in;
    logic [NB_LANES*DATA_WIDTH-1:0] b_in;
    logic [NB_LANES*ACC_WIDTH-1:0]  psum_in;
    logic [1:0]                     acc_src;
    logic                           last;
    logic                           reduce_mode;
    logic [SCALE_W-1:0]             out_scale;
    logic                           in_valid;
    logic                           in_ready;
    logic [NB_LANES*OUT_WIDTH-1:0]  out_data;
    logic [NB_LANES-1:0]            out_sat;
    logic                           out_valid;
    logic                           out_ready;
    logic                           busy;

    modport master (
        output a_in, b_in, psum_in, acc_src, last, reduce_mode, out_scale,
        output in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid, busy
    );

    modport slave (
        input  a_in, b_in, psum_in, acc_src, last, reduce_mode, out_scale,
        input  in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid, busy
    );
endinterface

// File: rtl/mac_lane_array.sv
// ---------------------------------------------------------------------------
// mac_lane_array
// NB_LANES parallel signed multiply-accumulate lanes with a registered output
// stage that emits either per-lane results or a cross-lane reduced sum, each
// arithmetically right-shifted by out_scale and saturated to OUT_WIDTH.
//
// Ports
//   clk        rising-edge clock
//   arst_n_in  asynchronous active-low reset
//   bus        mac_lane_array_if.slave (operand beats in, results out)
//   state_dbg  current FSM state (0 ACCUM, 1 FLUSH), for observation only
// ---------------------------------------------------------------------------
module mac_lane_array #(
    parameter int NB_LANES   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int MAX_SCALE  = 31
) (
    input  logic             clk,
    input  logic             arst_n_in,
    mac_lane_array_if.slave  bus,
    output logic             state_dbg
);
    localparam int SCALE_W = $clog2(MAX_SCALE + 1);
    localparam int PROD_W  = 2 * DATA_WIDTH;
    // Reduced sum needs log2(lanes) guard bits; also keep at least one bit
    // above OUT_WIDTH so the saturation bounds are representable.
    localparam int SUM_W   = ACC_WIDTH + $clog2(NB_LANES);
    localparam int EXT_W   = (SUM_W > OUT_WIDTH) ? SUM_W : OUT_WIDTH + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [ACC_WIDTH-1:0]  acc      [NB_LANES];
    logic signed [ACC_WIDTH-1:0]  acc_next [NB_LANES];
    logic signed [DATA_WIDTH-1:0] a_s      [NB_LANES];
    logic signed [DATA_WIDTH-1:0] b_s      [NB_LANES];
    logic signed [PROD_W-1:0]     prod     [NB_LANES];
    logic signed [ACC_WIDTH-1:0]  base     [NB_LANES];

    logic                          mode_q;
    logic [SCALE_W-1:0]            scale_q;
    logic [SCALE_W-1:0]            scale_c;
    logic                          in_ready_c;
    logic                          accept;
    logic                          load_out;

    logic [NB_LANES*OUT_WIDTH-1:0] out_data_q, out_data_n;
    logic [NB_LANES-1:0]           out_sat_q, out_sat_n;
    logic                          out_valid_q;

    // Clip a widened value into OUT_WIDTH; MSB of the result is the clip flag.
    function automatic logic [OUT_WIDTH:0] sat_fn(input logic signed [EXT_W-1:0] v);
        logic signed [EXT_W-1:0] hi;
        logic signed [EXT_W-1:0] lo;
        hi = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        lo = ~hi;
        if (v > hi) begin
            sat_fn = {1'b1, hi[OUT_WIDTH-1:0]};
        end else if (v < lo) begin
            sat_fn = {1'b1, lo[OUT_WIDTH-1:0]};
        end else begin
            sat_fn = {1'b0, v[OUT_WIDTH-1:0]};
        end
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // A beat is only taken when the output register will be free by the
    // FLUSH edge: either empty, or being consumed on this very edge.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        load_out   = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready_c = !(out_valid_q && !bus.out_ready);
                if (bus.in_valid && in_ready_c && bus.last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                load_out = 1'b1;
                state_d  = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    assign accept = bus.in_valid && in_ready_c;

    // ---------------- MAC lanes ----------------
    always_comb begin
        for (int i = 0; i < NB_LANES; i++) begin
            a_s[i]  = bus.a_in[i*DATA_WIDTH +: DATA_WIDTH];
            b_s[i]  = bus.b_in[i*DATA_WIDTH +: DATA_WIDTH];
            prod[i] = PROD_W'(a_s[i]) * PROD_W'(b_s[i]);
            case (bus.acc_src)
                2'd0:    base[i] = acc[i];
                2'd2:    base[i] = bus.psum_in[i*ACC_WIDTH +: ACC_WIDTH];
                default: base[i] = '0;
            endcase
            // Wraps modulo 2^ACC_WIDTH by construction.
            acc_next[i] = base[i] + ACC_WIDTH'(prod[i]);
        end
    end

    always_comb begin
        scale_c = bus.out_scale;
        if (32'(bus.out_scale) > 32'(MAX_SCALE)) begin
            scale_c = SCALE_W'(MAX_SCALE);
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < NB_LANES; i++) begin
                acc[i] <= '0;
            end
            mode_q  <= 1'b0;
            scale_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < NB_LANES; i++) begin
                acc[i] <= acc_next[i];
            end
            if (bus.last) begin
                mode_q  <= bus.reduce_mode;
                scale_q <= scale_c;
            end
        end
    end

    // ---------------- Output stage ----------------
    always_comb begin
        logic signed [EXT_W-1:0] red_sum;
        logic signed [EXT_W-1:0] shifted;
        logic [OUT_WIDTH:0]      clipped;
        out_data_n = '0;
        out_sat_n  = '0;
        red_sum    = '0;
        shifted    = '0;
        clipped    = '0;
        if (mode_q) begin
            for (int i = 0; i < NB_LANES; i++) begin
                red_sum = red_sum + EXT_W'(acc[i]);
            end
            shifted = red_sum >>> scale_q;
            clipped = sat_fn(shifted);
            out_data_n[OUT_WIDTH-1:0] = clipped[OUT_WIDTH-1:0];
            out_sat_n[0]              = clipped[OUT_WIDTH];
        end else begin
            for (int i = 0; i < NB_LANES; i++) begin
                shifted = EXT_W'(acc[i]) >>> scale_q;
                clipped = sat_fn(shifted);
                out_data_n[i*OUT_WIDTH +: OUT_WIDTH] = clipped[OUT_WIDTH-1:0];
                out_sat_n[i]                         = clipped[OUT_WIDTH];
            end
        end
    end

    // FLUSH never coincides with a pending result, so load and clear are
    // mutually exclusive.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            out_data_q  <= '0;
            out_sat_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_data_q  <= out_data_n;
            out_sat_q   <= out_sat_n;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == FLUSH) || out_valid_q;
    assign state_dbg     = (state_q == FLUSH);

endmodule

// File: tb/tb_mac_lane_array.sv
module tb_mac_lane_array;
    localparam int NB = 3;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int MS = 31;
    localparam int RW = NB + NB*OW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_n_in = 1'b0;
    logic state_dbg;
    always #5 clk = ~clk;

    mac_lane_array_if #(.NB_LANES(NB), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
                        .OUT_WIDTH(OW), .MAX_SCALE(MS)) bus ();

    mac_lane_array #(.NB_LANES(NB), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
                     .OUT_WIDTH(OW), .MAX_SCALE(MS)) dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model / scoreboard ----------------
    longint           macc [NB];
    logic [RW-1:0]    exp_q[$];
    int               checks = 0;
    int               errors = 0;

    function automatic longint clip(input longint v, output bit s);
        s = 1'b1;
        if (v > 32767)       return 32767;
        else if (v < -32768) return -32768;
        s = 1'b0;
        return v;
    endfunction

    // Result word: {sat[NB-1:0], slot[NB-1] ... slot[0]}
    function automatic logic [RW-1:0] model_result(input bit mode, input int scale);
        logic [RW-1:0] r;
        longint sum, v;
        bit s;
        int sc;
        r  = '0;
        sc = (scale > MS) ? MS : scale;
        if (mode) begin
            sum = 0;
            for (int i = 0; i < NB; i++) sum += macc[i];
            v = clip(sum >>> sc, s);
            r[OW-1:0] = v[OW-1:0];
            r[NB*OW]  = s;
        end else begin
            for (int i = 0; i < NB; i++) begin
                v = clip(macc[i] >>> sc, s);
                r[i*OW +: OW] = v[OW-1:0];
                r[NB*OW + i]  = s;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        bus.a_in        = {$urandom, $urandom};
        bus.b_in        = {$urandom, $urandom};
        bus.psum_in     = {$urandom, $urandom, $urandom};
        bus.acc_src     = 2'($urandom);
        bus.last        = 1'($urandom);
        bus.reduce_mode = 1'($urandom);
        bus.out_scale   = 5'($urandom);
    endtask

    task automatic send_beat(input int a[NB], input int b[NB], input int p[NB],
                             input int src, input bit last, input bit mode, input int scale);
        int n;
        longint base, t;
        for (int i = 0; i < NB; i++) begin
            bus.a_in[i*DW +: DW]    = a[i][DW-1:0];
            bus.b_in[i*DW +: DW]    = b[i][DW-1:0];
            bus.psum_in[i*AW +: AW] = p[i];
        end
        bus.acc_src     = 2'(src);
        bus.last        = last;
        bus.reduce_mode = mode;
        bus.out_scale   = 5'(scale);
        bus.in_valid    = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_wait", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < NB; i++) begin
            base = (src == 0) ? macc[i] : (src == 2) ? longint'(p[i]) : 0;
            t = base + longint'(a[i]) * longint'(b[i]);
            macc[i] = longint'(int'(t));
        end
        if (last) exp_q.push_back(model_result(mode, scale));
        step();
        bus.in_valid = 1'b0;
        junk_inputs();
    endtask

    task automatic get_result(input int hold);
        int n;
        logic [RW-1:0] e;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        check("out_valid_wait", 64'(bus.out_valid), 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int h = 0; h < hold; h++) begin
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_data", 64'(bus.out_data), 64'(e[NB*OW-1:0]));
            step();
        end
        check("out_data", 64'(bus.out_data), 64'(e[NB*OW-1:0]));
        check("out_sat", 64'(bus.out_sat), 64'(e[RW-1:NB*OW]));
        check("busy_pending", 64'(bus.busy), 64'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("out_valid_clear", 64'(bus.out_valid), 64'd0);
        check("in_ready_after", 64'(bus.in_ready), 64'd1);
    endtask

    function automatic int rnd_op();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 65535) - 32768;
        return $urandom_range(0, 600) - 300;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int a[NB], b[NB], p[NB];
        int z[NB];
        int nb;
        z = '{0, 0, 0};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        junk_inputs();
        for (int i = 0; i < NB; i++) macc[i] = 0;
        step();
        step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);
        arst_n_in = 1'b1;
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);

        // 1. single beat per-lane, latency check
        send_beat('{3, -2, 5}, '{4, 7, -1}, z, 1, 1'b1, 1'b0, 0);
        check("t1_flush_valid", 64'(bus.out_valid), 64'd0);
        check("t1_flush_state", 64'(state_dbg), 64'd1);
        check("t1_flush_busy", 64'(bus.busy), 64'd1);
        check("t1_flush_ready", 64'(bus.in_ready), 64'd0);
        step();
        check("t1_latency", 64'(bus.out_valid), 64'd1);
        check("t1_literal", 64'(bus.out_data), 64'({16'hfffb, 16'hfff2, 16'd12}));
        get_result(0);

        // 2. two-beat reduce
        send_beat('{1, 2, 3}, '{10, 10, 10}, z, 1, 1'b0, 1'b0, 0);
        send_beat('{1, 1, 1}, '{5, 5, 5}, z, 0, 1'b1, 1'b1, 0);
        get_result(0);

        // 3. external psum
        send_beat('{1, 1, 1}, '{1, 1, 1}, '{100, -100, 0}, 2, 1'b1, 1'b0, 0);
        get_result(0);

        // 4. scale / saturate
        send_beat('{32767, -32768, 64}, '{32767, 32767, 64}, z, 1, 1'b1, 1'b0, 4);
        step();
        check("t4_data", 64'(bus.out_data), 64'({16'd256, 16'h8000, 16'h7fff}));
        check("t4_sat", 64'(bus.out_sat), 64'(3'b011));
        get_result(0);

        // 5. backpressure
        send_beat('{7, 8, 9}, '{-3, 3, 100}, z, 1, 1'b1, 1'b0, 1);
        get_result(5);

        // 6. reset mid-accumulation
        send_beat('{9, 9, 9}, '{9, 9, 9}, z, 1, 1'b0, 1'b0, 0);
        send_beat('{5, 5, 5}, '{5, 5, 5}, z, 0, 1'b0, 1'b0, 0);
        #3 arst_n_in = 1'b0;
        for (int i = 0; i < NB; i++) macc[i] = 0;
        #1 check("t6_rst_valid0", 64'(bus.out_valid), 64'd0);
        step();
        check("t6_rst_valid1", 64'(bus.out_valid), 64'd0);
        arst_n_in = 1'b1;
        step();
        send_beat('{2, 2, 2}, '{2, 2, 2}, z, 0, 1'b1, 1'b0, 0);
        step();
        check("t6_data", 64'(bus.out_data), 64'({16'd4, 16'd4, 16'd4}));
        get_result(0);

        // random transactions
        for (int t = 0; t < 60; t++) begin
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                for (int i = 0; i < NB; i++) begin
                    a[i] = rnd_op();
                    b[i] = rnd_op();
                    p[i] = ($urandom_range(0, 1) == 1) ? int'($urandom) : $urandom_range(0, 2000) - 1000;
                end
                if ($urandom_range(0, 3) == 0) step();
                send_beat(a, b, p, $urandom_range(0, 3), (k == nb - 1),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3));
            end
            get_result($urandom_range(0, 3));
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
